// File: rtl/state_sequencer_pkg.sv
// Shared types for the instruction-level sequencer:
// FSM states, decoded instruction classes and control words.
package state_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } seq_state_e;

  typedef enum logic [1:0] {
    I_ALU    = 2'b00,
    I_LOAD   = 2'b01,
    I_STORE  = 2'b10,
    I_BRANCH = 2'b11
  } instr_e;

  localparam logic [1:0] WORD_NONE = 2'b00;
  localparam logic [1:0] WORD_MEM  = 2'b01;
  localparam logic [1:0] WORD_REG  = 2'b10;

endpackage

// File: rtl/state_sequencer_mem_wait_timer.sv
// Counts cycles spent waiting on memory; flags the
// cycle in which the wait budget runs out.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // last waiting cycle still without mem_ready
  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/state_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode,
// execute, memory and write-back control with timeout.
module state_sequencer
  import state_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic [1:0]       instr_type,
  input  logic             mem_ready,
  output logic [1:0]       state,
  output logic             ir_write,
  output logic             pc_write,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  seq_state_e       state_q, state_d;
  instr_e           instr_q, instr_d;
  logic             halt_pend_q, halt_pend_d;
  logic             error_q, error_d;
  logic             ir_write_q, ir_write_d;
  logic             pc_write_q, pc_write_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic       busy_w;
  logic       wait_en;
  logic       expired;
  logic       retire;
  seq_state_e after_retire;

  assign wait_en = ((state_q == S_FETCH) || (state_q == S_MEM))
                   && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_d != state_q),
    .enable (wait_en),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      instr_q     <= I_ALU;
      halt_pend_q <= 1'b0;
      error_q     <= 1'b0;
      ir_write_q  <= 1'b0;
      pc_write_q  <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      halt_pend_q <= halt_pend_d;
      error_q     <= error_d;
      ir_write_q  <= ir_write_d;
      pc_write_q  <= pc_write_d;
      retired_q   <= retired_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    error_d      = error_q;
    ir_write_d   = 1'b0;
    pc_write_d   = 1'b0;
    retire       = 1'b0;
    halt_pend_d  = halt_pend_q | (halt & busy_w);
    // a halt seen in the retiring cycle also counts
    after_retire = (halt_pend_q | halt) ? S_HALTED : S_FETCH;
    unique case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_ready) begin
          state_d    = S_DECODE;
          ir_write_d = 1'b1;
          pc_write_d = 1'b1;
        end else if (expired) begin
          error_d = 1'b1;
          state_d = S_HALTED;
        end
      end
      S_DECODE: begin
        instr_d = instr_e'(instr_type);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (instr_q)
          I_ALU:           state_d = S_WB;
          I_LOAD, I_STORE: state_d = S_MEM;
          I_BRANCH: begin
            pc_write_d = 1'b1;
            retire     = 1'b1;
            state_d    = after_retire;
          end
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (instr_q == I_LOAD) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = after_retire;
          end
        end else if (expired) begin
          error_d = 1'b1;
          state_d = S_HALTED;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = after_retire;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_comb begin
    state  = WORD_NONE;
    busy_w = 1'b1;
    unique case (state_q)
      S_FETCH, S_MEM:   state  = WORD_MEM;
      S_WB:             state  = WORD_REG;
      S_IDLE, S_HALTED: busy_w = 1'b0;
      default:          state  = WORD_NONE;
    endcase
  end

  assign busy     = busy_w;
  assign error    = error_q;
  assign ir_write = ir_write_q;
  assign pc_write = pc_write_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for the sequencer: instruction flows,
// memory timeout, halt, async reset and counter wrap.
module tb_state_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start, halt, mem_ready;
  logic [1:0]  instr_type;
  logic [1:0]  state_w;
  logic        ir_write, pc_write, busy, error;
  logic [15:0] retired;

  logic        start2, halt2, mem_ready2;
  logic [1:0]  instr2;
  logic [1:0]  state2;
  logic        ir2, pc2, busy2, err2;
  logic [3:0]  retired2;

  int errors = 0;
  int checks = 0;

  state_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .halt      (halt),
    .instr_type(instr_type),
    .mem_ready (mem_ready),
    .state     (state_w),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .busy      (busy),
    .error     (error),
    .retired   (retired)
  );

  state_sequencer #(.MEM_TIMEOUT(15), .CNT_W(4)) u_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .halt      (halt2),
    .instr_type(instr2),
    .mem_ready (mem_ready2),
    .state     (state2),
    .ir_write  (ir2),
    .pc_write  (pc2),
    .busy      (busy2),
    .error     (err2),
    .retired   (retired2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_word"}, 32'(state_w), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(error), 32'd0);
    chk({tag, "_ret"}, 32'(retired), 32'd0);
    chk({tag, "_ir"}, 32'(ir_write), 32'd0);
    chk({tag, "_pc"}, 32'(pc_write), 32'd0);
  endtask

  initial begin
    logic [3:0] prev;
    logic       saw_wrap;
    rst_n = 1'b0; start = 1'b0; halt = 1'b0;
    mem_ready = 1'b0; instr_type = 2'b00;
    start2 = 1'b0; halt2 = 1'b0;
    mem_ready2 = 1'b0; instr2 = 2'b11;

    @(negedge clk);
    chk_rst("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", 32'(busy), 32'd0);
    start = 1'b1; mem_ready = 1'b1; instr_type = 2'b00;

    // ALU: 01,00,00,10
    @(negedge clk);
    chk("alu_fetch", 32'(state_w), 32'd1);
    chk("alu_busy", 32'(busy), 32'd1);
    start = 1'b0;
    @(negedge clk);
    chk("alu_decode", 32'(state_w), 32'd0);
    chk("alu_irw", 32'(ir_write), 32'd1);
    chk("alu_pcw", 32'(pc_write), 32'd1);
    @(negedge clk);
    chk("alu_exec", 32'(state_w), 32'd0);
    chk("alu_irw_off", 32'(ir_write), 32'd0);
    instr_type = 2'b01;
    @(negedge clk);
    chk("alu_wb", 32'(state_w), 32'd2);
    chk("alu_ret_pre", 32'(retired), 32'd0);
    @(negedge clk);
    chk("alu_ret", 32'(retired), 32'd1);
    chk("load_fetch", 32'(state_w), 32'd1);

    // LOAD, mem_ready late by 3 cycles
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("load_exec", 32'(state_w), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("load_mem", 32'(state_w), 32'd1);
      mem_ready = (i == 3);
      @(negedge clk);
    end
    chk("load_wb", 32'(state_w), 32'd2);
    chk("load_ret_pre", 32'(retired), 32'd1);
    instr_type = 2'b10;
    @(negedge clk);
    chk("load_ret", 32'(retired), 32'd2);
    chk("load_err", 32'(error), 32'd0);

    // STORE completing on the last allowed cycle
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      chk("store_edge_mem", 32'(state_w), 32'd1);
      mem_ready = (i == 14);
      @(negedge clk);
    end
    chk("store_edge_err", 32'(error), 32'd0);
    chk("store_edge_ret", 32'(retired), 32'd3);
    chk("store_edge_busy", 32'(busy), 32'd1);

    // STORE with memory never ready
    @(negedge clk);
    chk("store2_irw", 32'(ir_write), 32'd1);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      chk("timeout_mem", 32'(state_w), 32'd1);
      chk("timeout_noerr", 32'(error), 32'd0);
      @(negedge clk);
    end
    chk("timeout_err", 32'(error), 32'd1);
    chk("timeout_word", 32'(state_w), 32'd0);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_ret", 32'(retired), 32'd3);
    start = 1'b1; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("halted_busy", 32'(busy), 32'd0);
    chk("halted_irw", 32'(ir_write), 32'd0);
    chk("halted_err", 32'(error), 32'd1);
    start = 1'b0;

    // halt during EXEC of an ALU op
    rst_n = 1'b0;
    #1;
    chk_rst("rst2");
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1;
    mem_ready = 1'b1; instr_type = 2'b00;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("halt_exec", 32'(state_w), 32'd0);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("halt_wb", 32'(state_w), 32'd2);
    @(negedge clk);
    chk("halt_ret", 32'(retired), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_word", 32'(state_w), 32'd0);
    @(negedge clk);
    chk("halt_irw", 32'(ir_write), 32'd0);
    chk("halt_stay", 32'(busy), 32'd0);

    // start and halt together in IDLE
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; halt = 1'b1;
    @(negedge clk);
    chk("sh_busy", 32'(busy), 32'd0);
    halt = 1'b0;
    @(negedge clk);
    chk("sh_terminal", 32'(busy), 32'd0);
    chk("sh_irw", 32'(ir_write), 32'd0);
    start = 1'b0;

    // async reset in the middle of a LOAD's MEM wait
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1;
    mem_ready = 1'b1; instr_type = 2'b01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_mem_word", 32'(state_w), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_rst("async_rst");
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    chk("post_rst_ret", 32'(retired), 32'd0);

    // retired counter wrap on a 4-bit instance
    start2 = 1'b1; mem_ready2 = 1'b1; instr2 = 2'b11;
    prev = retired2;
    saw_wrap = 1'b0;
    for (int i = 0; i < 200 && !saw_wrap; i++) begin
      @(negedge clk);
      if (retired2 != prev) begin
        if (prev == 4'hF) begin
          chk("wrap_zero", 32'(retired2), 32'd0);
          chk("wrap_busy", 32'(busy2), 32'd1);
          chk("wrap_pcw", 32'(pc2), 32'd1);
          saw_wrap = 1'b1;
        end
        prev = retired2;
      end
    end
    chk("wrap_seen", 32'(saw_wrap), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/state_sequencer.md
STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max cycles waiting on mem_ready before error.
REQ-002 Parameter CNT_W, default 16, width of retired-instruction counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  begin fetching from IDLE; ignored in other states.
REQ-006 halt  input  1  stop after current instruction retires.
REQ-007 instr_type  input  2  decoded class: 00 ALU, 01 LOAD, 10 STORE, 11 BRANCH; sampled in DECODE.
REQ-008 mem_ready  input  1  memory access complete this cycle.
REQ-009 state  output  2  control word: bit1 = register write phase, bit0 = memory phase.
REQ-010 ir_write  output  1  load instruction register.
REQ-011 pc_write  output  1  update PC.
REQ-012 busy  output  1  high in every state except IDLE and HALTED.
REQ-013 error  output  1  sticky memory-timeout flag.
REQ-014 retired  output  CNT_W  count of completed instructions.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED; all outputs registered or decoded from the state register only.
REQ-016 IDLE -> FETCH when start=1; otherwise hold.
REQ-017 FETCH SHALL drive state=01 and hold until mem_ready=1, then pulse ir_write=1 and pc_write=1 for that cycle and go to DECODE.
REQ-018 DECODE SHALL capture instr_type into an internal register and go to EXEC next cycle; state=00.
REQ-019 EXEC: ALU -> WB; LOAD/STORE -> MEM; BRANCH -> pulse pc_write=1, retire, next FETCH (or HALTED if halt pending); state=00.
REQ-020 MEM SHALL drive state=01 and hold until mem_ready=1; LOAD -> WB, STORE -> retire, then FETCH/HALTED.
REQ-021 WB SHALL drive state=10 for exactly one cycle, retire, then FETCH/HALTED.
REQ-022 state=11 SHALL never be driven.
REQ-023 Retire SHALL increment retired by 1 modulo 2^CNT_W (wrap from all-ones to 0, no saturation).
REQ-024 halt SHALL be latched as halt_pending on any cycle it is high while busy; at the next retire the FSM goes to HALTED instead of FETCH; halt in IDLE SHALL go directly to HALTED.
REQ-025 Simultaneous start and halt in IDLE: halt wins, go to HALTED.
REQ-026 Wait counter SHALL clear on entering FETCH or MEM and increment each cycle mem_ready=0; when it reaches MEM_TIMEOUT with mem_ready still 0, set error=1 and go to HALTED without retiring.
REQ-027 mem_ready=1 on the same cycle the counter reaches MEM_TIMEOUT SHALL complete normally (no error).
REQ-028 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-029 HALTED is terminal: only rst_n leaves it; state=00, all pulses 0.

Reset
REQ-030 On rst_n=0, asynchronously: FSM=IDLE, state=00, ir_write=0, pc_write=0, busy=0, error=0, retired=0, halt_pending=0, wait counter=0, captured instr_type=00.
REQ-031 Reset asserted mid-instruction SHALL abort it without retiring; after release the block sits in IDLE awaiting start.

Structure
REQ-032 A shared package SHALL hold the FSM state enumeration, the instr_type codes (ALU/LOAD/STORE/BRANCH) and the state-word constants (00 none, 01 memory, 10 register write).
REQ-033 The mem_ready wait/timeout counter SHALL be one sub-module, mem_wait_timer (inputs clear, enable; output expired).
REQ-034 The state output SHALL be consumed unchanged by the existing register-write/memory control decoder.

Verification
REQ-035 ALU: start, mem_ready=1 in FETCH, instr_type=00 -> state sequence 01,00,00,10; retired 0->1; 4 cycles per instruction.
REQ-036 LOAD with mem_ready delayed 3 cycles in MEM -> state=01 for 4 cycles then 10 for 1; retired increments once; error=0.
REQ-037 STORE with mem_ready never asserted -> error=1 and HALTED exactly MEM_TIMEOUT=15 cycles after MEM entry; retired unchanged; state=00.
REQ-038 halt pulsed during EXEC of an ALU instruction -> WB completes, retired+1, then HALTED; busy=0; no further ir_write.
REQ-039 Preload retired=16'hFFFF via back-to-back BRANCHes -> next retire gives 16'h0000.
REQ-040 rst_n pulsed low during MEM -> all outputs 00/0 immediately (asynchronously); IDLE after release; no retire.
